// File: rtl/pcap_dma_ctrl.sv
// pcap_dma_ctrl: sequences PCAP capture words into HP DMA write bursts, closes blocks, raises IRQs.
// Rev 1.0
`default_nettype none

module pcap_dma_ctrl #(
  parameter int BURST_LEN = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 arm_i,
  input  logic                 disarm_i,
  input  logic                 capt_done_i,
  input  logic                 dmaaddr_wstb_i,
  input  logic [31:0]          dmaaddr_i,
  input  logic [31:0]          block_size_i,
  input  logic [31:0]          timeout_i,
  input  logic [CNT_WIDTH-1:0] fifo_count_i,
  output logic                 dma_req_o,
  output logic [31:0]          dma_addr_o,
  output logic [8:0]           dma_len_o,
  input  logic                 dma_ack_i,
  input  logic                 dma_done_i,
  input  logic                 dma_err_i,
  output logic                 active_o,
  output logic                 irq_o,
  output logic [3:0]           irq_status_o,
  output logic [31:0]          smpl_count_o
);

  localparam logic [8:0]           BL9  = 9'(BURST_LEN);
  localparam logic [31:0]          BL32 = 32'(BURST_LEN);
  localparam logic [CNT_WIDTH-1:0] BLC  = CNT_WIDTH'(BURST_LEN);

  localparam logic [3:0] ST_BLOCK   = 4'd1;
  localparam logic [3:0] ST_CAPT    = 4'd2;
  localparam logic [3:0] ST_TIMEOUT = 4'd3;
  localparam logic [3:0] ST_DISARM  = 4'd4;
  localparam logic [3:0] ST_ADDR    = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_REQ   = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cur_addr, next_addr;
  logic        next_valid, addr_ovf;
  logic [31:0] wr_words, timer;
  logic        disarm_seen, capt_seen;

  logic        arm_ok, start_burst, close_term, close_blk;
  logic [3:0]  code;
  logic [8:0]  burst_len, flush_len;
  logic [31:0] room;
  logic        fifo_empty, fifo_ge_bl, room_ge_bl, block_full, expired, flush;

  assign room       = (block_size_i >> 2) - wr_words;
  assign fifo_empty = (fifo_count_i == '0);
  assign fifo_ge_bl = (fifo_count_i >= BLC);
  assign room_ge_bl = (room >= BL32);
  assign block_full = ((wr_words << 2) == block_size_i);
  assign expired    = (timeout_i != 32'd0) && (timer >= timeout_i);
  assign flush      = disarm_seen | capt_seen | expired;

  // Residual burst: smallest of FIFO level, block room and BURST_LEN.
  assign flush_len = fifo_ge_bl ? room[8:0] :
                     room_ge_bl ? fifo_count_i[8:0] :
                     (fifo_count_i[8:0] < room[8:0]) ? fifo_count_i[8:0] : room[8:0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    arm_ok      = 1'b0;
    start_burst = 1'b0;
    close_term  = 1'b0;
    close_blk   = 1'b0;
    code        = 4'd0;
    burst_len   = 9'd0;
    case (state)
      S_IDLE: begin
        if (arm_i) begin
          if (next_valid) begin
            arm_ok    = 1'b1;
            state_nxt = S_READY;
          end else begin
            close_term = 1'b1;
            code       = ST_ADDR;
          end
        end
      end
      S_READY: begin
        if (addr_ovf) begin
          close_term = 1'b1;
          code       = ST_ADDR;
        end else if (disarm_seen && fifo_empty) begin
          close_term = 1'b1;
          code       = ST_DISARM;
        end else if (capt_seen && fifo_empty) begin
          close_term = 1'b1;
          code       = ST_CAPT;
        end else if (block_full || (expired && wr_words != 32'd0 && fifo_empty)) begin
          if (next_valid) begin
            close_blk = 1'b1;
            code      = block_full ? ST_BLOCK : ST_TIMEOUT;
          end else begin
            close_term = 1'b1;
            code       = ST_ADDR;
          end
        end else if (fifo_ge_bl && room_ge_bl) begin
          start_burst = 1'b1;
          burst_len   = BL9;
        end else if (flush && !fifo_empty && room != 32'd0) begin
          start_burst = 1'b1;
          burst_len   = flush_len;
        end
        if (start_burst) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (dma_ack_i) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (dma_err_i) begin
          close_term = 1'b1;
          code       = ST_ADDR;
        end else if (dma_done_i) begin
          state_nxt = S_READY;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (close_term) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cur_addr     <= 32'd0;
      next_addr    <= 32'd0;
      next_valid   <= 1'b0;
      addr_ovf     <= 1'b0;
      wr_words     <= 32'd0;
      timer        <= 32'd0;
      disarm_seen  <= 1'b0;
      capt_seen    <= 1'b0;
      dma_req_o    <= 1'b0;
      dma_addr_o   <= 32'd0;
      dma_len_o    <= 9'd0;
      active_o     <= 1'b0;
      irq_o        <= 1'b0;
      irq_status_o <= 4'd0;
      smpl_count_o <= 32'd0;
    end else begin
      irq_o       <= 1'b0;
      disarm_seen <= disarm_seen | (disarm_i & active_o);
      capt_seen   <= capt_seen | (capt_done_i & active_o);

      // Opening a block consumes NEXT; a same-cycle strobe refills it.
      if (arm_ok || close_blk) begin
        cur_addr   <= next_addr;
        next_valid <= dmaaddr_wstb_i;
        if (dmaaddr_wstb_i) next_addr <= dmaaddr_i;
      end else if (dmaaddr_wstb_i) begin
        if (!active_o || !next_valid) begin
          next_addr  <= dmaaddr_i;
          next_valid <= 1'b1;
        end else begin
          addr_ovf <= 1'b1;
        end
      end

      if (arm_ok || close_blk) timer <= 32'd0;
      else if (active_o && timer != '1) timer <= timer + 32'd1;

      if (arm_ok || close_blk) wr_words <= 32'd0;
      else if (state == S_WAIT && dma_done_i && !dma_err_i) wr_words <= wr_words + 32'(dma_len_o);

      if (start_burst) begin
        dma_req_o  <= 1'b1;
        dma_addr_o <= cur_addr + (wr_words << 2);
        dma_len_o  <= burst_len;
      end else if (state == S_REQ && dma_ack_i) begin
        dma_req_o <= 1'b0;
      end

      if (arm_ok) active_o <= 1'b1;

      if (close_term || close_blk) begin
        irq_o        <= 1'b1;
        irq_status_o <= code;
        smpl_count_o <= wr_words;
      end

      if (close_term) begin
        active_o    <= 1'b0;
        next_valid  <= 1'b0;
        addr_ovf    <= 1'b0;
        wr_words    <= 32'd0;
        timer       <= 32'd0;
        disarm_seen <= 1'b0;
        capt_seen   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
